// File: rtl/lsu_mmio_bridge.sv
// -----------------------------------------------------------------------------
// lsu_mmio_bridge
//   Load/store unit for the MEMEX/WB stages. Each accepted access is decoded to
//   the data TCM, the instruction TCM or the peripheral bus. Store data is
//   lane-replicated with byte strobes. Load data is lane-aligned and sign- or
//   zero-extended. Peripheral accesses use a registered valid/ready handshake
//   with a wait timeout, and the pipeline is stalled while that handshake is
//   pending.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 access request (valid, we, addr, wdata, width, sext)
//   stall                 pipeline hold while a peripheral access is pending
//   rsp_valid/rsp_rdata   one-cycle completion pulse and aligned load data
//   fault/fault_cause     01 misaligned, 10 unmapped, 11 bus error/timeout
//   dtcm_we/itcm_we       TCM write enables (accept cycle only)
//   tcm_be/addr/wdata     shared TCM strobes, word-aligned offset, store data
//   dtcm_rdata/itcm_rdata TCM read data, one cycle after the address
//   periph_*              registered peripheral request / handshake inputs
// -----------------------------------------------------------------------------
module lsu_mmio_bridge #(
  parameter logic [31:0] PERIPH_BASE = 32'h0000_0000,
  parameter logic [31:0] PERIPH_SIZE = 32'h0000_1000,
  parameter logic [31:0] DTCM_BASE   = 32'h0000_1000,
  parameter logic [31:0] DTCM_SIZE   = 32'h0000_4000,
  parameter logic [31:0] ITCM_BASE   = 32'h0000_5000,
  parameter logic [31:0] ITCM_SIZE   = 32'h0000_4000,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_sext,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        dtcm_we,
  output logic        itcm_we,
  output logic [3:0]  tcm_be,
  output logic [31:0] tcm_addr,
  output logic [31:0] tcm_wdata,
  input  logic [31:0] dtcm_rdata,
  input  logic [31:0] itcm_rdata,
  output logic        periph_valid,
  output logic        periph_we,
  output logic [31:0] periph_addr,
  output logic [31:0] periph_wdata,
  output logic [3:0]  periph_be,
  input  logic        periph_ready,
  input  logic [31:0] periph_rdata,
  input  logic        periph_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PWAIT = 2'd1;
  localparam logic [1:0] S_PRESP = 2'd2;

  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  // Per-access shape kept from the accept cycle to format the response.
  typedef struct packed {
    logic [1:0] lane;
    logic [1:0] width;
    logic       sext;
    logic       we;
  } acc_info_t;

  function automatic logic [31:0] load_align(input logic [31:0] raw,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  width,
                                             input logic        sext);
    logic [31:0] sh;
    sh = raw >> {lane, 3'b000};
    case (width)
      2'b00:   load_align = {{24{sext & sh[7]}},  sh[7:0]};
      2'b01:   load_align = {{16{sext & sh[15]}}, sh[15:0]};
      default: load_align = sh;
    endcase
  endfunction

  // ---------------------------------------------------------------- state
  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  acc_info_t     info_q,      info_d;
  logic          imm_vld_q,   imm_vld_d;    // TCM / fault response due next cycle
  logic          imm_fault_q, imm_fault_d;
  logic [1:0]    imm_cause_q, imm_cause_d;
  logic [1:0]    src_q,       src_d;        // {itcm, dtcm} read source
  logic          pv_q,        pv_d;
  logic          pwe_q,       pwe_d;
  logic [31:0]   paddr_q,     paddr_d;
  logic [31:0]   pwdata_q,    pwdata_d;
  logic [3:0]    pbe_q,       pbe_d;
  logic [31:0]   prdata_q,    prdata_d;
  logic          pfault_q,    pfault_d;

  // --------------------------------------------------------------- decode
  logic        accept, misal, hit_p, hit_d, hit_i;
  logic [31:0] poff, doff, ioff;
  logic [3:0]  be;
  logic [31:0] wdata_rep;

  assign stall  = (state_q == S_PWAIT);
  assign accept = req_valid & ~stall;

  always_comb begin
    // Offset compare handles a window based at 0 without a >= 0 test.
    poff  = req_addr - PERIPH_BASE;
    doff  = req_addr - DTCM_BASE;
    ioff  = req_addr - ITCM_BASE;
    hit_p = (poff < PERIPH_SIZE);
    hit_d = ~hit_p & (doff < DTCM_SIZE);
    hit_i = ~hit_p & ~hit_d & (ioff < ITCM_SIZE);

    case (req_width)
      2'b00: begin
        misal     = 1'b0;
        be        = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misal     = req_addr[0];
        be        = 4'b0011 << req_addr[1:0];
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        misal     = |req_addr[1:0];
        be        = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // ------------------------------------------------------------ TCM ports
  always_comb begin
    dtcm_we   = accept & req_we & ~misal & hit_d;
    itcm_we   = accept & req_we & ~misal & hit_i;
    tcm_be    = (accept & ~misal & (hit_d | hit_i)) ? be : 4'b0000;
    tcm_wdata = wdata_rep;
    if (hit_d)      tcm_addr = doff & ~32'h3;
    else if (hit_i) tcm_addr = ioff & ~32'h3;
    else            tcm_addr = 32'h0;
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    info_d      = info_q;
    imm_vld_d   = 1'b0;
    imm_fault_d = 1'b0;
    imm_cause_d = 2'b00;
    src_d       = 2'b00;
    pv_d        = pv_q;
    pwe_d       = pwe_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pbe_d       = pbe_q;
    prdata_d    = prdata_q;
    pfault_d    = pfault_q;

    case (state_q)
      S_PWAIT: begin
        // Ready is checked first so a handshake on the timeout cycle wins.
        if (pv_q & periph_ready) begin
          pv_d     = 1'b0;
          prdata_d = periph_rdata;
          pfault_d = periph_err;
          state_d  = S_PRESP;
        end else if (cnt_q == CNT_LAST) begin
          pv_d     = 1'b0;
          pfault_d = 1'b1;
          state_d  = S_PRESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Acceptance is possible in IDLE and PRESP; it overrides PRESP -> IDLE.
    if (accept) begin
      info_d = '{lane: req_addr[1:0], width: req_width, sext: req_sext, we: req_we};
      if (misal) begin
        imm_vld_d   = 1'b1;
        imm_fault_d = 1'b1;
        imm_cause_d = 2'b01;
      end else if (hit_p) begin
        pv_d     = 1'b1;
        pwe_d    = req_we;
        paddr_d  = req_addr;
        pwdata_d = wdata_rep;
        pbe_d    = be;
        prdata_d = 32'h0;
        pfault_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_PWAIT;
      end else if (hit_d | hit_i) begin
        imm_vld_d = 1'b1;
        src_d     = {hit_i, hit_d};
      end else begin
        imm_vld_d   = 1'b1;
        imm_fault_d = 1'b1;
        imm_cause_d = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      info_q      <= '0;
      imm_vld_q   <= 1'b0;
      imm_fault_q <= 1'b0;
      imm_cause_q <= 2'b00;
      src_q       <= 2'b00;
      pv_q        <= 1'b0;
      pwe_q       <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      pbe_q       <= 4'h0;
      prdata_q    <= 32'h0;
      pfault_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      info_q      <= info_d;
      imm_vld_q   <= imm_vld_d;
      imm_fault_q <= imm_fault_d;
      imm_cause_q <= imm_cause_d;
      src_q       <= src_d;
      pv_q        <= pv_d;
      pwe_q       <= pwe_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pbe_q       <= pbe_d;
      prdata_q    <= prdata_d;
      pfault_q    <= pfault_d;
    end
  end

  // -------------------------------------------------------------- outputs
  logic        presp;
  logic [31:0] raw;

  assign periph_valid = pv_q;
  assign periph_we    = pwe_q;
  assign periph_addr  = paddr_q;
  assign periph_wdata = pwdata_q;
  assign periph_be    = pbe_q;

  // An immediate response and PRESP can never coincide: a TCM/fault access
  // accepted in cycle N leaves the FSM in IDLE at N+1.
  always_comb begin
    presp       = (state_q == S_PRESP);
    rsp_valid   = imm_vld_q | presp;
    fault       = (imm_vld_q & imm_fault_q) | (presp & pfault_q);
    fault_cause = imm_vld_q ? imm_cause_q : ((presp & pfault_q) ? 2'b11 : 2'b00);
    if (presp)         raw = prdata_q;
    else if (src_q[0]) raw = dtcm_rdata;
    else               raw = itcm_rdata;
    rsp_rdata = (rsp_valid & ~fault & ~info_q.we)
              ? load_align(raw, info_q.lane, info_q.width, info_q.sext) : 32'h0;
  end

endmodule
